// File: rtl/btb_predictor_if.sv
// rtl/btb_predictor_if.sv - fetch/execute side bundle of the branch target buffer
//
// Groups the IF lookup, EX update/redirect and statistics signals.
//   master : core side (drives LOOKUP_PC, UPD_*, FLUSH; receives predictions/redirect/stats)
//   slave  : btb_predictor side
interface btb_predictor_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] LOOKUP_PC;
    logic              PRED_HIT;
    logic              PRED_TAKEN;
    logic [ADDR_W-1:0] PRED_TARGET;
    logic              UPD_VALID;
    logic [ADDR_W-1:0] UPD_PC;
    logic              UPD_TAKEN;
    logic [ADDR_W-1:0] UPD_TARGET;
    logic              UPD_PRED_TAKEN;
    logic [ADDR_W-1:0] UPD_PRED_TARGET;
    logic              FLUSH;
    logic              MISPREDICT;
    logic [ADDR_W-1:0] REDIRECT_PC;
    logic [31:0]       STAT_LOOKUPS;
    logic [31:0]       STAT_MISPRED;

    modport master (
        output LOOKUP_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET,
               UPD_PRED_TAKEN, UPD_PRED_TARGET, FLUSH,
        input  PRED_HIT, PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC,
               STAT_LOOKUPS, STAT_MISPRED
    );

    modport slave (
        input  LOOKUP_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET,
               UPD_PRED_TAKEN, UPD_PRED_TARGET, FLUSH,
        output PRED_HIT, PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC,
               STAT_LOOKUPS, STAT_MISPRED
    );
endinterface

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// IF looks up LOOKUP_PC combinationally and gets a next-PC prediction in the same
// cycle. EX reports resolved control transfers on UPD_*; the block raises MISPREDICT
// with REDIRECT_PC and trains the table on the following posedge.
//
// Ports:
//   CLK   : clock, all state updates on posedge
//   RSTn  : synchronous active-low reset (overrides FLUSH and updates)
//   bus   : btb_predictor_if.slave - lookup, update, flush, redirect, statistics
//
// Optional feature macro: BTB_STATS_EN (update / mispredict counters on
// STAT_LOOKUPS / STAT_MISPRED; without it both read 32'h0).
module btb_predictor #(
    parameter int         ENTRIES  = 16,
    parameter int         ADDR_W   = 12,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic             CLK,
    input  logic             RSTn,
    btb_predictor_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];

    // Lookup path
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;

    assign lk_idx   = bus.LOOKUP_PC[IDX_W+1:2];
    assign lk_tag   = bus.LOOKUP_PC[ADDR_W-1:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && cnt_q[lk_idx][1];

    assign bus.PRED_HIT    = lk_hit;
    assign bus.PRED_TAKEN  = lk_taken;
    assign bus.PRED_TARGET = lk_taken ? target_q[lk_idx] : bus.LOOKUP_PC + ADDR_W'(4);

    // Resolution path: comparing the full next PC catches both direction and
    // target errors, so the carried UPD_PRED_TAKEN bit is not needed here.
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic [ADDR_W-1:0] actual_next;
    logic              mispredict;

    assign up_idx      = bus.UPD_PC[IDX_W+1:2];
    assign up_tag      = bus.UPD_PC[ADDR_W-1:IDX_W+2];
    assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign actual_next = bus.UPD_TAKEN ? bus.UPD_TARGET : bus.UPD_PC + ADDR_W'(4);
    assign mispredict  = bus.UPD_VALID && (actual_next != bus.UPD_PRED_TARGET);

    assign bus.MISPREDICT  = mispredict;
    assign bus.REDIRECT_PC = mispredict ? actual_next : '0;

    logic unused_pred_taken;
    assign unused_pred_taken = bus.UPD_PRED_TAKEN;

    // Training is suppressed by reset and by FLUSH.
    logic train;
    assign train = RSTn && !bus.FLUSH && bus.UPD_VALID;

    always_ff @(posedge CLK) begin
        if (!RSTn || bus.FLUSH) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
        end else if (bus.UPD_VALID) begin
            if (up_hit) begin
                if (bus.UPD_TAKEN) begin
                    if (cnt_q[up_idx] != 2'b11)
                        cnt_q[up_idx] <= cnt_q[up_idx] + 2'd1;
                end else begin
                    if (cnt_q[up_idx] != 2'b00)
                        cnt_q[up_idx] <= cnt_q[up_idx] - 2'd1;
                end
            end else if (bus.UPD_TAKEN) begin
                valid_q[up_idx] <= 1'b1;
                cnt_q[up_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target need no reset: they are only meaningful when valid is set.
    // Every taken update writes both; on a hit the tag is rewritten with itself.
    always_ff @(posedge CLK) begin
        if (train && bus.UPD_TAKEN) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.UPD_TARGET;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stat_lookups_q <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (bus.UPD_VALID)
                stat_lookups_q <= stat_lookups_q + 32'd1;
            if (mispredict)
                stat_mispred_q <= stat_mispred_q + 32'd1;
        end
    end

    assign bus.STAT_LOOKUPS = stat_lookups_q;
    assign bus.STAT_MISPRED = stat_mispred_q;
`else
    assign bus.STAT_LOOKUPS = 32'h0;
    assign bus.STAT_MISPRED = 32'h0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed self-checking bench for btb_predictor
module tb_btb_predictor;
    localparam int ADDR_W = 12;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    btb_predictor_if #(.ADDR_W(ADDR_W)) bus ();

    btb_predictor #(
        .ENTRIES (16),
        .ADDR_W  (ADDR_W),
        .CNT_INIT(2'b01)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_lookups = 0;
    int exp_mispred = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [11:0] pc,
                          input logic hit, input logic taken, input logic [11:0] tgt);
        bus.LOOKUP_PC = pc;
        #1;
        check({tag, "_hit"},    32'(bus.PRED_HIT),    32'(hit));
        check({tag, "_taken"},  32'(bus.PRED_TAKEN),  32'(taken));
        check({tag, "_target"}, 32'(bus.PRED_TARGET), 32'(tgt));
    endtask

    // Drives one resolved update for a single clock edge; checks the
    // combinational redirect before the edge.
    task automatic update(input string tag, input logic [11:0] pc, input logic taken,
                          input logic [11:0] tgt, input logic [11:0] pred, input logic flush,
                          input logic exp_mis, input logic [11:0] exp_redir);
        bus.UPD_VALID       = 1'b1;
        bus.UPD_PC          = pc;
        bus.UPD_TAKEN       = taken;
        bus.UPD_TARGET      = tgt;
        bus.UPD_PRED_TARGET = pred;
        bus.UPD_PRED_TAKEN  = (pred != pc + 12'd4);
        bus.FLUSH           = flush;
        #1;
        check({tag, "_mis"},   32'(bus.MISPREDICT),  32'(exp_mis));
        check({tag, "_redir"}, 32'(bus.REDIRECT_PC), exp_mis ? 32'(exp_redir) : 32'h0);
        if (RSTn) begin
            exp_lookups++;
            if (exp_mis) exp_mispred++;
        end
        @(posedge CLK);
        #1;
        bus.UPD_VALID = 1'b0;
        bus.FLUSH     = 1'b0;
    endtask

    initial begin
        bus.LOOKUP_PC       = '0;
        bus.UPD_VALID       = 1'b0;
        bus.UPD_PC          = '0;
        bus.UPD_TAKEN       = 1'b0;
        bus.UPD_TARGET      = '0;
        bus.UPD_PRED_TAKEN  = 1'b0;
        bus.UPD_PRED_TARGET = '0;
        bus.FLUSH           = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        // Reset state
        lookup("rst", 12'h010, 1'b0, 1'b0, 12'h014);
        check("rst_mis",   32'(bus.MISPREDICT), 32'h0);
        check("rst_stat_l", bus.STAT_LOOKUPS, 32'h0);
        check("rst_stat_m", bus.STAT_MISPRED, 32'h0);

        // Allocate 0x020; a lookup in the same cycle sees the old (empty) entry
        bus.LOOKUP_PC = 12'h020;
        bus.UPD_VALID = 1'b1; bus.UPD_PC = 12'h020; bus.UPD_TAKEN = 1'b1;
        bus.UPD_TARGET = 12'h100; bus.UPD_PRED_TARGET = 12'h024;
        #1;
        check("same_cyc_hit", 32'(bus.PRED_HIT), 32'h0);
        update("alloc", 12'h020, 1'b1, 12'h100, 12'h024, 1'b0, 1'b1, 12'h100);
        lookup("alloc_lk", 12'h020, 1'b1, 1'b1, 12'h100);

        // Counter down to 00 with saturation, then back up to 11 with saturation
        update("nt1", 12'h020, 1'b0, 12'h100, 12'h100, 1'b0, 1'b1, 12'h024);
        lookup("nt1_lk", 12'h020, 1'b1, 1'b0, 12'h024);
        update("nt2", 12'h020, 1'b0, 12'h100, 12'h024, 1'b0, 1'b0, 12'h000);
        update("nt3", 12'h020, 1'b0, 12'h100, 12'h024, 1'b0, 1'b0, 12'h000);
        lookup("nt3_lk", 12'h020, 1'b1, 1'b0, 12'h024);
        update("t4", 12'h020, 1'b1, 12'h100, 12'h024, 1'b0, 1'b1, 12'h100);
        lookup("t4_lk", 12'h020, 1'b1, 1'b0, 12'h024);
        update("t5", 12'h020, 1'b1, 12'h100, 12'h024, 1'b0, 1'b1, 12'h100);
        lookup("t5_lk", 12'h020, 1'b1, 1'b1, 12'h100);
        update("t6", 12'h020, 1'b1, 12'h100, 12'h100, 1'b0, 1'b0, 12'h000);
        update("t7", 12'h020, 1'b1, 12'h100, 12'h100, 1'b0, 1'b0, 12'h000);
        update("nt8", 12'h020, 1'b0, 12'h100, 12'h100, 1'b0, 1'b1, 12'h024);
        lookup("nt8_lk", 12'h020, 1'b1, 1'b1, 12'h100);

        // Target error with correct direction retrains the target
        update("tgt", 12'h020, 1'b1, 12'h200, 12'h100, 1'b0, 1'b1, 12'h200);
        lookup("tgt_lk", 12'h020, 1'b1, 1'b1, 12'h200);

        // Conflict: 0x060 shares index 8 with 0x020
        update("conf", 12'h060, 1'b1, 12'h300, 12'h064, 1'b0, 1'b1, 12'h300);
        lookup("conf_old", 12'h020, 1'b0, 1'b0, 12'h024);
        lookup("conf_new", 12'h060, 1'b1, 1'b1, 12'h300);

        // Miss and not taken leaves the table alone
        update("miss_nt", 12'h0A0, 1'b0, 12'h700, 12'h0A4, 1'b0, 1'b0, 12'h000);
        lookup("miss_nt_lk", 12'h060, 1'b1, 1'b1, 12'h300);
        lookup("miss_nt_lk2", 12'h0A0, 1'b0, 1'b0, 12'h0A4);

        // PC wrap-around
        lookup("wrap", 12'hFFC, 1'b0, 1'b0, 12'h000);
        update("wrap_upd", 12'hFFC, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000);
        update("wrap_mis", 12'hFFC, 1'b0, 12'h000, 12'h800, 1'b0, 1'b1, 12'h000);

        // Idle update bus must read zero even with garbage on it
        bus.UPD_PC = 12'h123; bus.UPD_TAKEN = 1'b1; bus.UPD_TARGET = 12'h456;
        bus.UPD_PRED_TARGET = 12'h789;
        #1;
        check("idle_mis",   32'(bus.MISPREDICT),  32'h0);
        check("idle_redir", 32'(bus.REDIRECT_PC), 32'h0);

        // FLUSH wins over a simultaneous update, redirect still driven
        update("alloc40", 12'h040, 1'b1, 12'h400, 12'h044, 1'b0, 1'b1, 12'h400);
        lookup("alloc40_lk", 12'h040, 1'b1, 1'b1, 12'h400);
        update("flush", 12'h040, 1'b1, 12'h500, 12'h400, 1'b1, 1'b1, 12'h500);
        lookup("flush_40", 12'h040, 1'b0, 1'b0, 12'h044);
        lookup("flush_60", 12'h060, 1'b0, 1'b0, 12'h064);

        check("stat_lookups", bus.STAT_LOOKUPS,
`ifdef BTB_STATS_EN
              32'(exp_lookups));
`else
              32'h0);
`endif
        check("stat_mispred", bus.STAT_MISPRED,
`ifdef BTB_STATS_EN
              32'(exp_mispred));
`else
              32'h0);
`endif

        // Reset overrides an update in the same edge; stats cleared
        RSTn = 1'b0;
        update("rst_upd", 12'h080, 1'b1, 12'h600, 12'h084, 1'b0, 1'b1, 12'h600);
        RSTn = 1'b1;
        lookup("rst_upd_lk", 12'h080, 1'b0, 1'b0, 12'h084);
        check("rst_stat_l2", bus.STAT_LOOKUPS, 32'h0);
        check("rst_stat_m2", bus.STAT_MISPRED, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
